// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer holding {pc, instr} pairs with flush
import fetch_pkg::*;

module fetch_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            empty;
  logic            wr_en;
  logic            rd_en;

  always_comb begin
    full  = (count == CW'(DEPTH));
    empty = (count == '0);
    wr_en = push & ~full;
    rd_en = pop & ~empty;
  end

  // Pointers are exactly AW bits so they wrap at DEPTH without extra logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch initiator with buffering and redirect squash
import fetch_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_instr,
  input  logic        imem_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] inflight_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  logic              issue;
  logic              push;
  logic              pop;
  logic              valid;
  fetch_entry_t      push_data;
  fetch_entry_t      head;

  // Space check counts the outstanding read but not a same-cycle pop, so a
  // response always has a free slot when it lands.
  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    issue     = rst_n & fetch_en & ~redirect & (occupancy < (CW+1)'(FIFO_DEPTH));
    valid     = (count != '0) & ~redirect;
    push      = imem_ready & inflight & ~redirect;
    pop       = valid & out_ready;
    push_data = '{pc: inflight_pc, instr: imem_instr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      if (redirect) begin
        pc <= redirect_pc;
      end else if (issue) begin
        pc <= pc + 32'd1;
      end
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign imem_addr  = pc;
  assign imem_rd_en = issue;
  assign out_valid  = valid;
  assign out_instr  = head.instr;
  assign out_pc     = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_instr;
  logic        imem_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  int issued = 0;

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rd_en  (imem_rd_en),
    .imem_instr  (imem_instr),
    .imem_ready  (imem_ready),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word[i] = i + 100, one-cycle latency.
  initial begin
    imem_ready = 1'b0;
    imem_instr = '0;
  end
  always @(posedge clk) begin
    imem_ready <= imem_rd_en;
    imem_instr <= imem_addr + 32'd100;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    fetch_en    = 1'b1;
    out_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;

    // reset state
    repeat (2) cyc();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rd_en", imem_rd_en, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);

    // streaming from reset
    cyc(); rst_n = 1'b1; #1;
    chk("c0_rd_en", imem_rd_en, 1);
    chk("c0_addr", imem_addr, 0);
    chk("c0_valid", out_valid, 0);
    cyc(); #1;
    chk("c1_valid", out_valid, 0);
    chk("c1_addr", imem_addr, 1);
    for (int c = 2; c <= 7; c++) begin
      cyc(); #1;
      chk("stream_valid", out_valid, 1);
      chk("stream_pc", out_pc, 32'(c - 2));
      chk("stream_instr", out_instr, 32'(c + 98));
    end

    // backpressure from reset
    cyc(); rst_n = 1'b0; out_ready = 1'b0; #1;
    chk("bp_rst_valid", out_valid, 0);
    cyc(); rst_n = 1'b1; issued = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      issued += int'(imem_rd_en);
      cyc();
    end
    out_ready = 1'b1; #1;
    chk("bp_issued", issued, 4);
    chk("bp_rd_en_stopped", imem_rd_en, 0);
    for (int c = 10; c <= 17; c++) begin
      if (c > 10) begin
        cyc(); #1;
      end
      if (c == 11) begin
        chk("bp_resume_rd_en", imem_rd_en, 1);
        chk("bp_resume_addr", imem_addr, 4);
      end
      chk("bp_drain_valid", out_valid, 1);
      chk("bp_drain_pc", out_pc, 32'(c - 10));
      chk("bp_drain_instr", out_instr, 32'(c + 90));
    end

    // redirect while the read to PC 7 is in flight
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    repeat (7) cyc();
    #1;
    chk("pre_redir_pc", out_pc, 5);
    cyc(); redirect = 1'b1; redirect_pc = 32'h40; #1;
    chk("redir_addr_before", imem_addr, 8);
    chk("redir_valid_forced", out_valid, 0);
    chk("redir_no_issue", imem_rd_en, 0);
    cyc(); redirect = 1'b0; #1;
    chk("redir1_valid", out_valid, 0);
    chk("redir1_rd_en", imem_rd_en, 1);
    chk("redir1_addr", imem_addr, 32'h40);
    cyc(); #1;
    chk("redir2_valid", out_valid, 0);
    chk("redir2_addr", imem_addr, 32'h41);
    cyc(); #1;
    chk("redir3_valid", out_valid, 1);
    chk("redir3_pc", out_pc, 32'h40);
    chk("redir3_instr", out_instr, 32'd164);
    cyc(); #1;
    chk("redir4_pc", out_pc, 32'h41);
    chk("redir4_instr", out_instr, 32'd165);

    // fetch_en dropped for 5 cycles
    cyc(); fetch_en = 1'b0; #1;
    chk("fe_off_rd_en", imem_rd_en, 0);
    chk("fe_off_pc0", out_pc, 32'h42);
    cyc(); #1;
    chk("fe_inflight_valid", out_valid, 1);
    chk("fe_inflight_pc", out_pc, 32'h43);
    chk("fe_inflight_instr", out_instr, 32'h43 + 32'd100);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("fe_idle_rd_en", imem_rd_en, 0);
      chk("fe_idle_valid", out_valid, 0);
    end
    cyc(); fetch_en = 1'b1; #1;
    chk("fe_resume_rd_en", imem_rd_en, 1);
    chk("fe_resume_addr", imem_addr, 32'h44);
    cyc(); #1;
    chk("fe_resume_addr2", imem_addr, 32'h45);
    chk("fe_resume_valid0", out_valid, 0);
    cyc(); out_ready = 1'b0; #1;
    chk("fe_resume_out_valid", out_valid, 1);
    chk("fe_resume_out_pc", out_pc, 32'h44);

    // asynchronous reset with three entries buffered
    cyc();
    cyc(); #1;
    chk("hold_pc", out_pc, 32'h44);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_rd_en", imem_rd_en, 0);
    chk("async_rst_pc", out_pc, 0);
    chk("async_rst_instr", out_instr, 0);
    cyc();
    cyc(); rst_n = 1'b1; out_ready = 1'b1; #1;
    chk("restart_addr", imem_addr, 0);
    chk("restart_rd_en", imem_rd_en, 1);
    cyc(); #1;
    chk("restart_valid_c1", out_valid, 0);
    cyc(); #1;
    chk("restart_valid_c2", out_valid, 1);
    chk("restart_pc", out_pc, 0);
    chk("restart_instr", out_instr, 32'd100);

    // redirect to the top of the address space
    cyc(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    chk("wrap_redir_valid", out_valid, 0);
    cyc(); redirect = 1'b0; #1;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFF);
    cyc(); #1;
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    cyc(); #1;
    chk("wrap_pc0", out_pc, 32'hFFFF_FFFF);
    chk("wrap_instr0", out_instr, 32'd99);
    cyc(); #1;
    chk("wrap_pc1", out_pc, 32'h0000_0000);
    chk("wrap_instr1", out_instr, 32'd100);
    cyc(); #1;
    chk("wrap_pc2", out_pc, 32'h0000_0001);
    chk("wrap_valid2", out_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
